// File: rtl/kronos_arb_pkg.sv
// rtl/kronos_arb_pkg.sv - shared types and constants for the Kronos memory arbiter
package kronos_arb_pkg;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   vld;
    owner_e own;
    logic   vld_t0;
    logic   own_t0;
  } rsp_t;

  localparam logic PRIO_RST = 1'b1;

endpackage

// File: rtl/kronos_arb_taint_mux.sv
// rtl/kronos_arb_taint_mux.sv - 2:1 mux with precise taint shadow on the select
module kronos_arb_taint_mux #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic         sel_t0,
  input  logic [W-1:0] a,
  input  logic [W-1:0] a_t0,
  input  logic [W-1:0] b,
  input  logic [W-1:0] b_t0,
  output logic [W-1:0] y,
  output logic [W-1:0] y_t0
);

  // sel=1 picks b; a tainted select taints every bit where the inputs differ
  always_comb begin
    y    = sel ? b : a;
    y_t0 = sel_t0 ? ((a ^ b) | a_t0 | b_t0) : (sel ? b_t0 : a_t0);
  end

endmodule

// File: rtl/kronos_mem_arbiter.sv
// rtl/kronos_mem_arbiter.sv - taint-aware instr/data arbiter for one single-port SRAM
module kronos_mem_arbiter
  import kronos_arb_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          instr_req,
  input  logic          instr_req_t0,
  output logic          instr_gnt,
  output logic          instr_gnt_t0,
  input  logic [AW-1:0] instr_addr,
  input  logic [AW-1:0] instr_addr_t0,
  output logic          instr_rvalid,
  output logic          instr_rvalid_t0,
  output logic [DW-1:0] instr_rdata,
  output logic [DW-1:0] instr_rdata_t0,
  input  logic          data_req,
  input  logic          data_req_t0,
  output logic          data_gnt,
  output logic          data_gnt_t0,
  input  logic [AW-1:0] data_addr,
  input  logic [AW-1:0] data_addr_t0,
  input  logic          data_we,
  input  logic          data_we_t0,
  input  logic [DW-1:0] data_wdata,
  input  logic [DW-1:0] data_wdata_t0,
  input  logic [DW-1:0] data_strb,
  input  logic [DW-1:0] data_strb_t0,
  output logic          data_rvalid,
  output logic          data_rvalid_t0,
  output logic [DW-1:0] data_rdata,
  output logic [DW-1:0] data_rdata_t0,
  output logic          mem_req,
  output logic          mem_req_t0,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_addr_t0,
  output logic          mem_we,
  output logic          mem_we_t0,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_wdata_t0,
  output logic [DW-1:0] mem_strb,
  output logic [DW-1:0] mem_strb_t0,
  input  logic [DW-1:0] mem_rdata,
  input  logic [DW-1:0] mem_rdata_t0
);

  logic prio_q;
  logic prio_t0_q;
  rsp_t rsp_q;

  logic conflict;
  logic win_data;
  logic win_instr;
  logic sel_t0;
  logic rd_gnt;
  logic rd_gnt_t0;
  logic instr_own;
  logic data_own;
  logic rsp_live;

  // Grant decision: a lone requester wins, otherwise the priority holder wins
  always_comb begin
    conflict  = instr_req & data_req;
    win_data  = data_req & (~instr_req | prio_q);
    win_instr = instr_req & ~win_data;
    sel_t0    = (instr_req_t0 & (data_req | data_req_t0))
              | (data_req_t0 & (instr_req | instr_req_t0))
              | (prio_t0_q & conflict);
  end

  assign instr_gnt    = win_instr;
  assign data_gnt     = win_data;
  assign instr_gnt_t0 = instr_req_t0 | sel_t0;
  assign data_gnt_t0  = data_req_t0 | sel_t0;

  assign mem_req    = instr_req | data_req;
  assign mem_req_t0 = (instr_req_t0 & ~data_req) | (data_req_t0 & ~instr_req)
                    | (instr_req_t0 & data_req_t0);

  // Instruction side never writes: its we/wdata/strb legs are constant zero
  kronos_arb_taint_mux #(.W(AW)) u_mux_addr (
    .sel(win_data), .sel_t0(sel_t0),
    .a(instr_addr), .a_t0(instr_addr_t0),
    .b(data_addr),  .b_t0(data_addr_t0),
    .y(mem_addr),   .y_t0(mem_addr_t0)
  );

  kronos_arb_taint_mux #(.W(1)) u_mux_we (
    .sel(win_data), .sel_t0(sel_t0),
    .a(1'b0),       .a_t0(1'b0),
    .b(data_we),    .b_t0(data_we_t0),
    .y(mem_we),     .y_t0(mem_we_t0)
  );

  kronos_arb_taint_mux #(.W(DW)) u_mux_wdata (
    .sel(win_data),  .sel_t0(sel_t0),
    .a('0),          .a_t0('0),
    .b(data_wdata),  .b_t0(data_wdata_t0),
    .y(mem_wdata),   .y_t0(mem_wdata_t0)
  );

  kronos_arb_taint_mux #(.W(DW)) u_mux_strb (
    .sel(win_data),  .sel_t0(sel_t0),
    .a('0),          .a_t0('0),
    .b(data_strb),   .b_t0(data_strb_t0),
    .y(mem_strb),    .y_t0(mem_strb_t0)
  );

  // A granted read expects data next cycle; writes produce no response
  always_comb begin
    rd_gnt    = mem_req & ~mem_we;
    rd_gnt_t0 = mem_req_t0 | (mem_req & mem_we_t0);
  end

  // Priority flips toward the loser on conflicts; response regs reload every cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q    <= PRIO_RST;
      prio_t0_q <= 1'b0;
      rsp_q     <= '0;
    end else begin
      if (conflict)
        prio_q <= win_instr;
      if (conflict | sel_t0)
        prio_t0_q <= sel_t0;
      rsp_q.vld    <= rd_gnt;
      rsp_q.own    <= win_data ? OWN_DATA : OWN_INSTR;
      rsp_q.vld_t0 <= rd_gnt_t0;
      rsp_q.own_t0 <= sel_t0;
    end
  end

  // Route the SRAM read data to the port that owns the outstanding response
  always_comb begin
    instr_own = rsp_q.vld & (rsp_q.own == OWN_INSTR);
    data_own  = rsp_q.vld & (rsp_q.own == OWN_DATA);
    rsp_live  = rsp_q.vld | rsp_q.vld_t0;
  end

  assign instr_rvalid    = instr_own;
  assign data_rvalid     = data_own;
  assign instr_rvalid_t0 = rsp_q.vld_t0 | rsp_q.own_t0;
  assign data_rvalid_t0  = rsp_q.vld_t0 | rsp_q.own_t0;

  assign instr_rdata = instr_own ? mem_rdata : '0;
  assign data_rdata  = data_own  ? mem_rdata : '0;

  assign instr_rdata_t0 = (rsp_q.own_t0 & rsp_live) ? (mem_rdata | mem_rdata_t0)
                        : (instr_own ? mem_rdata_t0 : '0);
  assign data_rdata_t0  = (rsp_q.own_t0 & rsp_live) ? (mem_rdata | mem_rdata_t0)
                        : (data_own ? mem_rdata_t0 : '0);

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// tb/tb_kronos_mem_arbiter.sv - directed self-checking bench for kronos_mem_arbiter
module tb_kronos_mem_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          instr_req, instr_req_t0, instr_gnt, instr_gnt_t0;
  logic [AW-1:0] instr_addr, instr_addr_t0;
  logic          instr_rvalid, instr_rvalid_t0;
  logic [DW-1:0] instr_rdata, instr_rdata_t0;
  logic          data_req, data_req_t0, data_gnt, data_gnt_t0;
  logic [AW-1:0] data_addr, data_addr_t0;
  logic          data_we, data_we_t0;
  logic [DW-1:0] data_wdata, data_wdata_t0, data_strb, data_strb_t0;
  logic          data_rvalid, data_rvalid_t0;
  logic [DW-1:0] data_rdata, data_rdata_t0;
  logic          mem_req, mem_req_t0;
  logic [AW-1:0] mem_addr, mem_addr_t0;
  logic          mem_we, mem_we_t0;
  logic [DW-1:0] mem_wdata, mem_wdata_t0, mem_strb, mem_strb_t0;
  logic [DW-1:0] mem_rdata, mem_rdata_t0;

  int checks = 0;
  int errors = 0;

  logic taint_any;
  assign taint_any = instr_gnt_t0 | instr_rvalid_t0 | (|instr_rdata_t0)
                   | data_gnt_t0 | data_rvalid_t0 | (|data_rdata_t0)
                   | mem_req_t0 | (|mem_addr_t0) | mem_we_t0
                   | (|mem_wdata_t0) | (|mem_strb_t0);

  always #5 clk_i = ~clk_i;

  kronos_mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req(instr_req), .instr_req_t0(instr_req_t0),
    .instr_gnt(instr_gnt), .instr_gnt_t0(instr_gnt_t0),
    .instr_addr(instr_addr), .instr_addr_t0(instr_addr_t0),
    .instr_rvalid(instr_rvalid), .instr_rvalid_t0(instr_rvalid_t0),
    .instr_rdata(instr_rdata), .instr_rdata_t0(instr_rdata_t0),
    .data_req(data_req), .data_req_t0(data_req_t0),
    .data_gnt(data_gnt), .data_gnt_t0(data_gnt_t0),
    .data_addr(data_addr), .data_addr_t0(data_addr_t0),
    .data_we(data_we), .data_we_t0(data_we_t0),
    .data_wdata(data_wdata), .data_wdata_t0(data_wdata_t0),
    .data_strb(data_strb), .data_strb_t0(data_strb_t0),
    .data_rvalid(data_rvalid), .data_rvalid_t0(data_rvalid_t0),
    .data_rdata(data_rdata), .data_rdata_t0(data_rdata_t0),
    .mem_req(mem_req), .mem_req_t0(mem_req_t0),
    .mem_addr(mem_addr), .mem_addr_t0(mem_addr_t0),
    .mem_we(mem_we), .mem_we_t0(mem_we_t0),
    .mem_wdata(mem_wdata), .mem_wdata_t0(mem_wdata_t0),
    .mem_strb(mem_strb), .mem_strb_t0(mem_strb_t0),
    .mem_rdata(mem_rdata), .mem_rdata_t0(mem_rdata_t0)
  );

  task automatic clear_inputs();
    instr_req = 0; instr_req_t0 = 0; instr_addr = '0; instr_addr_t0 = '0;
    data_req = 0; data_req_t0 = 0; data_addr = '0; data_addr_t0 = '0;
    data_we = 0; data_we_t0 = 0; data_wdata = '0; data_wdata_t0 = '0;
    data_strb = '0; data_strb_t0 = '0; mem_rdata = '0; mem_rdata_t0 = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    #3;
    checks++; if (instr_gnt !== 1'b0 || data_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b%b exp 00", instr_gnt, data_gnt); end
    checks++; if (instr_rvalid !== 1'b0 || data_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b%b exp 00", instr_rvalid, data_rvalid); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0) begin errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h exp 0", mem_req, mem_we, mem_addr); end
    checks++; if (instr_rdata !== '0 || data_rdata !== '0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0", instr_rdata, data_rdata); end
    checks++; if (taint_any !== 1'b0) begin errors++; $display("FAIL reset_taint got %b exp 0", taint_any); end
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;
  endtask

  task automatic test_instr_read();
    do_reset();
    tick();
    instr_req = 1; instr_addr = 15'h10;
    #1;
    checks++; if (instr_gnt !== 1'b1 || data_gnt !== 1'b0) begin errors++; $display("FAIL ird_gnt got %b%b exp 10", instr_gnt, data_gnt); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 15'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL ird_mem got req=%b addr=%h we=%b exp 1 010 0", mem_req, mem_addr, mem_we); end
    checks++; if (taint_any !== 1'b0) begin errors++; $display("FAIL ird_taint0 got %b exp 0", taint_any); end
    tick();
    instr_req = 0; instr_addr = '0; mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++; if (instr_rvalid !== 1'b1 || instr_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL ird_rsp got v=%b d=%h exp 1 cafef00d", instr_rvalid, instr_rdata); end
    checks++; if (data_rvalid !== 1'b0 || data_rdata !== '0) begin errors++; $display("FAIL ird_nonowner got v=%b d=%h exp 0 0", data_rvalid, data_rdata); end
    checks++; if (taint_any !== 1'b0) begin errors++; $display("FAIL ird_taint1 got %b exp 0", taint_any); end
    tick();
    #1;
    checks++; if (instr_rvalid !== 1'b0) begin errors++; $display("FAIL ird_idle got %b exp 0", instr_rvalid); end
  endtask

  task automatic test_conflict();
    logic prev_data;
    logic exp_d;
    do_reset();
    tick();
    instr_addr = 15'h11; data_addr = 15'h22;
    instr_req = 1;
    #1;
    checks++; if (instr_gnt !== 1'b1) begin errors++; $display("FAIL cfl_solo got %b exp 1", instr_gnt); end
    prev_data = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      instr_req = 1; data_req = 1; mem_rdata = 32'h1000_0000 + i;
      #1;
      exp_d = (i % 2 == 0);
      checks++; if (data_gnt !== exp_d || instr_gnt !== !exp_d) begin errors++; $display("FAIL cfl_gnt[%0d] got d=%b i=%b exp d=%b", i, data_gnt, instr_gnt, exp_d); end
      checks++; if (mem_addr !== (exp_d ? 15'h22 : 15'h11)) begin errors++; $display("FAIL cfl_addr[%0d] got %h exp %h", i, mem_addr, exp_d ? 15'h22 : 15'h11); end
      checks++; if (data_rvalid !== prev_data || instr_rvalid !== !prev_data) begin errors++; $display("FAIL cfl_rsp[%0d] got d=%b i=%b exp d=%b", i, data_rvalid, instr_rvalid, prev_data); end
      checks++; if ((prev_data ? data_rdata : instr_rdata) !== 32'h1000_0000 + i) begin errors++; $display("FAIL cfl_rdata[%0d] got %h exp %h", i, prev_data ? data_rdata : instr_rdata, 32'h1000_0000 + i); end
      prev_data = exp_d;
    end
    tick();
    clear_inputs();
    #1;
    checks++; if (instr_rvalid !== 1'b1 || data_rvalid !== 1'b0) begin errors++; $display("FAIL cfl_last got i=%b d=%b exp 1 0", instr_rvalid, data_rvalid); end
  endtask

  task automatic test_write();
    do_reset();
    tick();
    data_req = 1; data_we = 1; data_addr = '0; data_wdata = '0; data_strb = 32'hFFFF_FFFF;
    #1;
    checks++; if (data_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== '0) begin errors++; $display("FAIL wr_mem got gnt=%b we=%b addr=%h exp 1 1 0", data_gnt, mem_we, mem_addr); end
    checks++; if (mem_strb !== 32'hFFFF_FFFF || mem_wdata !== '0) begin errors++; $display("FAIL wr_strb got strb=%h wdata=%h exp ffffffff 0", mem_strb, mem_wdata); end
    tick();
    clear_inputs(); mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin errors++; $display("FAIL wr_norsp got d=%b i=%b exp 0 0", data_rvalid, instr_rvalid); end
    checks++; if (data_rdata !== '0) begin errors++; $display("FAIL wr_rdata got %h exp 0", data_rdata); end
  endtask

  task automatic test_taint_conflict();
    do_reset();
    tick();
    instr_req = 1; instr_req_t0 = 1;
    #1;
    checks++; if (mem_req_t0 !== 1'b1 || instr_gnt_t0 !== 1'b1 || data_gnt_t0 !== 1'b0) begin errors++; $display("FAIL tsolo got mreq=%b ig=%b dg=%b exp 1 1 0", mem_req_t0, instr_gnt_t0, data_gnt_t0); end
    do_reset();
    tick();
    instr_req = 1; instr_req_t0 = 1; data_req = 1;
    instr_addr = 15'h0F0; data_addr = 15'h00F;
    #1;
    checks++; if (instr_gnt_t0 !== 1'b1 || data_gnt_t0 !== 1'b1) begin errors++; $display("FAIL tcfl_gnt got %b%b exp 11", instr_gnt_t0, data_gnt_t0); end
    checks++; if (mem_addr_t0 !== 15'h0FF || mem_addr !== 15'h00F) begin errors++; $display("FAIL tcfl_addr got t0=%h a=%h exp 0ff 00f", mem_addr_t0, mem_addr); end
    checks++; if (mem_req_t0 !== 1'b0 || mem_we_t0 !== 1'b0) begin errors++; $display("FAIL tcfl_req got req_t0=%b we_t0=%b exp 0 0", mem_req_t0, mem_we_t0); end
    tick();
    clear_inputs(); mem_rdata = 32'h1234_0000; mem_rdata_t0 = 32'h0000_00F0;
    #1;
    checks++; if (data_rdata_t0 !== 32'h1234_00F0 || instr_rdata_t0 !== 32'h1234_00F0) begin errors++; $display("FAIL tcfl_rdt0 got d=%h i=%h exp 123400f0", data_rdata_t0, instr_rdata_t0); end
    checks++; if (data_rdata !== 32'h1234_0000 || instr_rdata !== '0) begin errors++; $display("FAIL tcfl_rdata got d=%h i=%h exp 12340000 0", data_rdata, instr_rdata); end
    checks++; if (data_rvalid_t0 !== 1'b1 || instr_rvalid_t0 !== 1'b1) begin errors++; $display("FAIL tcfl_rv_t0 got %b%b exp 11", data_rvalid_t0, instr_rvalid_t0); end
  endtask

  task automatic test_rdata_taint();
    do_reset();
    tick();
    data_req = 1; data_addr = 15'h5;
    #1;
    checks++; if (taint_any !== 1'b0) begin errors++; $display("FAIL rdt_clean got %b exp 0", taint_any); end
    tick();
    clear_inputs(); mem_rdata = 32'hA5A5_0000; mem_rdata_t0 = 32'h0000_00FF;
    #1;
    checks++; if (data_rdata_t0 !== 32'h0000_00FF || instr_rdata_t0 !== '0) begin errors++; $display("FAIL rdt_t0 got d=%h i=%h exp ff 0", data_rdata_t0, instr_rdata_t0); end
    checks++; if (data_rvalid_t0 !== 1'b0 || data_rdata !== 32'hA5A5_0000) begin errors++; $display("FAIL rdt_val got vt0=%b d=%h exp 0 a5a50000", data_rvalid_t0, data_rdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    instr_req = 1; data_req = 1; instr_addr = 15'h7; data_addr = 15'h9;
    #1;
    checks++; if (data_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", data_gnt); end
    tick();
    clear_inputs(); mem_rdata = 32'h5555_AAAA;
    #1;
    checks++; if (data_rvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", data_rvalid); end
    rst_ni = 1'b0;
    #1;
    checks++; if (data_rvalid !== 1'b0 || data_rdata !== '0) begin errors++; $display("FAIL rmid_drop got v=%b d=%h exp 0 0", data_rvalid, data_rdata); end
    @(posedge clk_i);
    #2 rst_ni = 1'b1;
    tick();
    #1;
    checks++; if (data_rvalid !== 1'b0 || instr_rvalid !== 1'b0) begin errors++; $display("FAIL rmid_post got d=%b i=%b exp 0 0", data_rvalid, instr_rvalid); end
    instr_req = 1; data_req = 1;
    #1;
    checks++; if (data_gnt !== 1'b1 || instr_gnt !== 1'b0) begin errors++; $display("FAIL rmid_prio got d=%b i=%b exp 1 0", data_gnt, instr_gnt); end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_conflict();
    test_write();
    test_taint_conflict();
    test_rdata_taint();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
